// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-copy DMA initiator on the data-memory port (one read then one write per word).
// Optional running checksum of words read: define MEMCPY_CHECKSUM_EN to enable; otherwise checksum_o is tied to 0.
module mem_copy_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [DATA_W-1:0] checksum_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [DATA_W-1:0] mem_wd_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rd_i
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] FIN  = 3'd3;
    localparam logic [2:0] ABT  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              accept;

    assign accept = (state_q == IDLE) && start_i;

    // Next-state and datapath: capture on start, latch read word in RD, advance index in WR
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (start_i) begin
                src_d   = src_addr_i;
                dst_d   = dst_addr_i;
                len_d   = len_i;
                idx_d   = '0;
                state_d = (len_i != '0) ? RD : FIN;
            end
            RD: begin
                buf_d   = mem_rd_i;
                state_d = abort_i ? ABT : WR;
            end
            WR: begin
                idx_d   = idx_q + LEN_W'(1);
                state_d = abort_i ? ABT : ((idx_q + LEN_W'(1) == len_q) ? FIN : RD);
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; async reset stops a copy at once since mem_we is decoded from state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    assign busy_o    = (state_q == RD) || (state_q == WR);
    assign done_o    = (state_q == FIN);
    assign aborted_o = (state_q == ABT);
    assign mem_we_o  = (state_q == WR);
    assign mem_a_o   = (state_q == RD) ? src_q + ADDR_W'(idx_q) :
                       (state_q == WR) ? dst_q + ADDR_W'(idx_q) : '0;
    assign mem_wd_o  = (state_q == WR) ? buf_q : '0;

`ifdef MEMCPY_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    // Checksum clears on an accepted start, accumulates each word read, holds otherwise
    always_comb chk_d = accept ? '0 : (state_q == RD) ? chk_q + mem_rd_i : chk_q;

    // Checksum register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) chk_q <= '0;
        else chk_q <= chk_d;
    end

    assign checksum_o = chk_q;
`else
    assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: scoreboard bench with a word-level copy model and a 64-word memory
module tb_mem_copy_engine;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [31:0] src = 0, dst = 0;
    logic [10:0] len = 0;
    logic        busy, done, aborted, mem_we;
    logic [31:0] checksum, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pl_we = 0;
    logic [5:0]  pl_a = 0;
    logic [31:0] pl_d = 0;
    int          cyc = 0, errs = 0, checks = 0, busy_lo = 1, busy_hi = 0;

    typedef struct {int c; logic [31:0] a; logic [31:0] d;} wr_t;
    typedef struct {int c; bit ab; logic [31:0] s;} ev_t;
    wr_t wq[$];
    ev_t evq[$];
    wr_t mw;
    ev_t me;

    mem_copy_engine dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_addr_i(src), .dst_addr_i(dst),
        .len_i(len), .abort_i(abort), .busy_o(busy), .done_o(done), .aborted_o(aborted),
        .checksum_o(checksum), .mem_a_o(mem_a), .mem_wd_o(mem_wd), .mem_we_o(mem_we),
        .mem_rd_i(mem_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[5:0]] <= mem_wd;
        else if (pl_we) mem[pl_a] <= pl_d;
    end
    assign mem_rd = mem[mem_a[5:0]];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expected writes/events whenever the DUT presents them
    always @(negedge clk) if (rst_n) begin
        chk("busy", {31'b0, busy}, {31'b0, cyc >= busy_lo && cyc <= busy_hi});
        if (!busy) chk("we_idle", {31'b0, mem_we}, 0);
        if (!busy && !done && !aborted) chk("idle_bus", mem_a | mem_wd, 0);
        chk("done_and_aborted", {31'b0, done & aborted}, 0);
        if (mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", mem_a, mem_wd);
            end else begin
                mw = wq.pop_front();
                chk("wr_cycle", cyc, mw.c);
                chk("wr_addr", mem_a, mw.a);
                chk("wr_data", mem_wd, mw.d);
            end
        end
        if (done || aborted) begin
            if (evq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_event: done %b aborted %b, none expected", done, aborted);
            end else begin
                me = evq.pop_front();
                chk("ev_cycle", cyc, me.c);
                chk("ev_aborted", {31'b0, aborted}, {31'b0, me.ab});
                chk("checksum", checksum, me.s);
            end
        end
    end

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1;
        pl_a = 6'(a);
        pl_d = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_we = 0;
    endtask

    // One copy: ac = abort cycle (0 none), rc = reset cycle (0 none), rep = re-pulse start while busy
    task automatic copy(input int s, input int d, input int n, input int ac, input int rc, input bit rep);
        int e0, stop, bad;
        logic [31:0] sum, v;
        @(negedge clk);
        e0 = cyc;
        stop = ac > 0 ? ac : rc > 0 ? rc - 1 : 2 * n;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            if (2 * k + 1 <= stop) sum += ref_mem[s + k];
            if (2 * k + 2 <= stop) begin
                v = ref_mem[s + k];
                ref_mem[d + k] = v;
                wq.push_back('{e0 + 2 * k + 2, 32'(d + k), v});
            end
        end
`ifndef MEMCPY_CHECKSUM_EN
        sum = 0;
`endif
        if (rc == 0) evq.push_back('{e0 + stop + 1, ac > 0, sum});
        busy_lo = e0 + 1;
        busy_hi = e0 + stop;
        start = 1;
        src = 32'(s);
        dst = 32'(d);
        len = 11'(n);
        @(negedge clk);
        start = 0;
        src = $urandom;
        dst = $urandom;
        len = 11'($urandom);
        for (int c = 1; c <= stop + 2; c++) begin
            if (rep && c == 2) begin
                start = 1;
                src = 32'(s + 20);
                dst = 32'(d + 30);
                len = 3;
            end
            if (rep && c == 3) start = 0;
            abort = (ac > 0 && c == ac);
            if (rc > 0 && c == rc - 1) begin
                @(posedge clk);
                #1 rst_n = 0;
                #1 chk("rst_flags", {28'b0, busy, done, aborted, mem_we}, 0);
                chk("rst_bus", mem_a | mem_wd | checksum, 0);
                repeat (2) @(negedge clk);
                rst_n = 1;
                break;
            end
            @(negedge clk);
        end
        abort = 0;
        @(negedge clk);
        chk("drain", wq.size() + evq.size(), 0);
        wq.delete();
        evq.delete();
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s, d, n, ac;
        #12;
        chk("reset_flags", {28'b0, busy, done, aborted, mem_we}, 0);
        chk("reset_bus", mem_a | mem_wd | checksum, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 64; i++) poke(i, i < 5 ? 32'(1) << (4 * i) : $urandom);
        copy(0, 8, 5, 0, 0, 0);
        copy(3, 20, 0, 0, 0, 0);
        copy(0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) poke(i, 32'(1) << (4 * i));
        for (int i = 8; i < 13; i++) poke(i, 0);
        copy(0, 8, 5, 4, 0, 0);
        copy(0, 8, 5, 0, 0, 1);
        for (int i = 8; i < 13; i++) poke(i, 0);
        copy(0, 8, 5, 0, 3, 0);
        copy(0, 8, 5, 0, 0, 0);
        for (int t = 0; t < 25; t++) begin
            s = $urandom_range(0, 40);
            d = $urandom_range(0, 40);
            n = $urandom_range(0, 12);
            ac = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : 0;
            copy(s, d, n, ac, 0, 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Word-copy DMA engine that acts as the initiator on the data-memory port. It drives the address, write-data and write-enable inputs of the data memory and samples its read-data output. Given a source address, destination address and word count, it copies the block in ascending address order, one read cycle followed by one write cycle per word. It sits beside the core's load/store path and shares the data memory through an external mux owned by the integrator.

## Interface
- ADDR_W, 32, width of memory word address (memory is word-addressed)
- DATA_W, 32, memory data width
- LEN_W, 11, width of word-count input (max 2^LEN_W−1 words)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address; captured on accepted start
- dst_addr  in  ADDR_W  first destination word address; captured on accepted start
- len  in  LEN_W  number of words; captured on accepted start
- abort  in  1  cancel an in-progress copy
- busy  out  1  high in RD and WR states
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse after abort
- checksum  out  DATA_W  running sum of words read (see Configuration)
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DATA_W  memory read data (combinational from mem_a while mem_we=0)

## Operation
- States: IDLE, RD, WR, FIN, ABT.
- IDLE: mem_we=0, mem_a=0, mem_wd=0, busy=0. On start=1, capture src/dst/len, clear idx and checksum; next state RD if len≠0, else FIN.
- RD: mem_a=src+idx, mem_we=0. At edge: buf<=mem_rd, checksum+=mem_rd (if enabled); next WR.
- WR: mem_a=dst+idx, mem_wd=buf, mem_we=1. At edge the memory writes; idx<=idx+1; next FIN if idx+1==len, else RD.
- FIN: done=1, mem_we=0; next IDLE.
- ABT: aborted=1, mem_we=0; next IDLE.
- abort=1 in RD or WR: go to ABT at that edge; in WR the current write still commits (mem_we already high). abort is ignored in IDLE/FIN/ABT.
- start outside IDLE is ignored; no queuing.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Overlapping ranges are copied strictly ascending, word by word; dst>src overlaps propagate source data (defined, not an error).
- checksum is modulo 2^DATA_W. It holds after FIN/ABT until the next accepted start.

## Timing
- Reset: state IDLE; busy, done, aborted, mem_we = 0; mem_a, mem_wd, checksum, buf, idx = 0. Reset asserted mid-copy stops immediately and performs no further writes.
- With start accepted at edge E0: word k is read in cycle 2k+1 and written in cycle 2k+2 (cycles after E0). done is high in cycle 2·len+1. busy is high in cycles 1..2·len.
- len=0: done is high in cycle 1 and no memory access occurs.
- done and aborted are never high together; each lasts exactly one cycle.
- Next start is accepted no earlier than the edge ending FIN/ABT.

## Configuration
- MEMCPY_CHECKSUM_EN defined: checksum accumulates every word captured in RD, as described.
- Not defined: no accumulator logic; the checksum port remains and is driven constant 0.

## Test plan
- Memory preloaded mem[0..4]=1,0x10,0x100,0x1000,0x10000; start src=0 dst=8 len=5 -> mem[8..12] equal those values; done in cycle 11; busy high cycles 1..10; checksum=0x11111 (0 without macro).
- start len=0 -> done in cycle 1; mem_we never high; memory unchanged.
- Overlap: src=0 dst=1 len=3 -> mem[1..3]=1,1,1; done in cycle 7.
- abort raised in cycle 4 (WR of word 1) of src=0 dst=8 len=5 copy -> mem[8]=1, mem[9]=0x10, mem[10..12] untouched; aborted in cycle 5; no done.
- start re-pulsed while busy with different src/dst -> ignored; the original copy completes unchanged.
- reset driven low in cycle 3 of the first copy -> all outputs 0 immediately; mem[9..12] not written; a fresh start afterwards completes normally.
